// File: rtl/pipe_inst_enc_pkg.sv
// Shared definitions for the instruction encoder: opsel codes, MIPS-style
// op/func constants, FSM state encoding and word-packing helpers.
package pipe_inst_enc_pkg;

  typedef enum logic [4:0] {
    SEL_ADD  = 5'd0,  SEL_SUB  = 5'd1,  SEL_AND  = 5'd2,  SEL_OR   = 5'd3,
    SEL_XOR  = 5'd4,  SEL_SLL  = 5'd5,  SEL_SRL  = 5'd6,  SEL_SRA  = 5'd7,
    SEL_JR   = 5'd8,  SEL_ADDI = 5'd9,  SEL_ANDI = 5'd10, SEL_ORI  = 5'd11,
    SEL_XORI = 5'd12, SEL_LW   = 5'd13, SEL_SW   = 5'd14, SEL_BEQ  = 5'd15,
    SEL_BNE  = 5'd16, SEL_LUI  = 5'd17, SEL_J    = 5'd18, SEL_JAL  = 5'd19
  } opsel_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/pipe_inst_enc_fmt.sv
// Combinational formatter: opsel plus operand fields to a 32-bit instruction
// word, with an illegal flag for unassigned opsel codes.
module pipe_inst_fmt
  import pipe_inst_enc_pkg::*;
(
  input  logic [4:0]  opsel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (opsel_e'(opsel))
      SEL_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      SEL_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      SEL_AND:  word = r_word(rs, rt, rd, 5'd0, FN_AND);
      SEL_OR:   word = r_word(rs, rt, rd, 5'd0, FN_OR);
      SEL_XOR:  word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      // Shifts take their source from rt; the rs slot is zeroed
      SEL_SLL:  word = r_word(5'd0, rt, rd, sa, FN_SLL);
      SEL_SRL:  word = r_word(5'd0, rt, rd, sa, FN_SRL);
      SEL_SRA:  word = r_word(5'd0, rt, rd, sa, FN_SRA);
      SEL_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      SEL_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      SEL_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      SEL_ORI:  word = i_word(OP_ORI,  rs, rt, imm);
      SEL_XORI: word = i_word(OP_XORI, rs, rt, imm);
      SEL_LW:   word = i_word(OP_LW,   rs, rt, imm);
      SEL_SW:   word = i_word(OP_SW,   rs, rt, imm);
      SEL_BEQ:  word = i_word(OP_BEQ,  rs, rt, imm);
      SEL_BNE:  word = i_word(OP_BNE,  rs, rt, imm);
      SEL_LUI:  word = i_word(OP_LUI,  5'd0, rt, imm);
      SEL_J:    word = j_word(OP_J,   target);
      SEL_JAL:  word = j_word(OP_JAL, target);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_inst_enc.sv
// Instruction encoder: accepts one request at a time, writes the encoded word
// to sequential instruction-memory addresses until DEPTH words are written.
module pipe_inst_enc
  import pipe_inst_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  opsel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [10:0] count,
  output logic        full,
  output logic        err
);

  logic [1:0]  state;
  logic [31:0] word_p0;
  logic        illegal_p0;
  logic [31:0] word_p1;
  logic        vld_p1;
  logic [31:0] addr_q;
  logic [10:0] count_q;
  logic        full_q;
  logic        err_q;

  pipe_inst_fmt u_fmt (
    .opsel   (opsel),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .sa      (sa),
    .imm     (imm),
    .target  (target),
    .word    (word_p0),
    .illegal (illegal_p0)
  );

  // clear blocks acceptance in the same cycle so it always wins over a handshake
  assign req_ready = (state == ST_IDLE) && !clear;

  // p0 -> p1: accepted word registered, write strobe issued next cycle
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state   <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (illegal_p0) begin
              err_q <= 1'b1;
            end else begin
              word_p1 <= word_p0;
              vld_p1  <= 1'b1;
              state   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          vld_p1  <= 1'b0;
          addr_q  <= addr_q + 32'd4;
          count_q <= count_q + 11'd1;
          if (count_q == 11'(DEPTH - 1)) begin
            full_q <= 1'b1;
            state  <= ST_FULL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FULL: state <= ST_FULL;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = vld_p1;
  assign imem_wdata = word_p1;
  assign imem_addr  = addr_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pipe_inst_enc.sv
// Bench for pipe_inst_enc: transaction-level reference model compared every
// cycle, plus directed vectors with literal expected words and addresses.
module tb_pipe_inst_enc;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  opsel = '0, rs = '0, rt = '0, rd = '0, sa = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [10:0] count;
  logic        full, err;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  pipe_inst_enc #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear(clear), .req_valid(req_valid),
    .req_ready(req_ready), .opsel(opsel), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
    .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from the instruction-set tables with plain arithmetic
  function automatic logic [32:0] ref_enc(input int sel, input int f_rs, input int f_rt,
                                          input int f_rd, input int f_sa, input int f_imm,
                                          input int f_tgt);
    int func_t [9] = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
    int op_t   [9] = '{8, 12, 13, 14, 35, 43, 4, 5, 15};
    longint w;
    if (sel > 19) return {1'b1, 32'h0};
    if (sel <= 8) begin
      if (sel >= 5 && sel <= 7) f_rs = 0;
      else if (sel == 8) begin f_rt = 0; f_rd = 0; f_sa = 0; end
      else f_sa = 0;
      w = func_t[sel] + f_sa * 64 + f_rd * 2048 + f_rt * 65536 + f_rs * 2097152;
    end else if (sel <= 17) begin
      if (sel == 17) f_rs = 0;
      w = longint'(op_t[sel-9]) * 67108864 + f_rs * 2097152 + f_rt * 65536 + f_imm;
    end else begin
      w = longint'(sel == 18 ? 2 : 3) * 67108864 + f_tgt;
    end
    return {1'b0, 32'(w)};
  endfunction

  // Model state: a pending write is visible for exactly one cycle after acceptance
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_count;
  logic        m_full, m_err;
  logic [32:0] m_enc;
  logic [31:0] wr_log[$];

  always @(posedge clock) begin
    m_enc = ref_enc(int'(opsel), int'(rs), int'(rt), int'(rd), int'(sa), int'(imm), int'(target));
    if (reset || clear) begin
      m_we = 0; m_addr = 0; m_wdata = 0; m_count = 0; m_full = 0; m_err = 0;
      model_on = 1'b1;
    end else if (m_we) begin
      m_we = 0;
      m_addr = m_addr + 4;
      m_count++;
      if (m_count == DEPTH) m_full = 1;
    end else if (!m_full && req_valid) begin
      if (m_enc[32]) m_err = 1;
      else begin m_we = 1; m_wdata = m_enc[31:0]; end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("m_we", 32'(imem_we), 32'(m_we));
      chk("m_addr", imem_addr, m_addr);
      chk("m_wdata", imem_wdata, m_wdata);
      chk("m_count", 32'(count), 32'(m_count));
      chk("m_full", 32'(full), 32'(m_full));
      chk("m_err", 32'(err), 32'(m_err));
      if (!clear) chk("m_ready", 32'(req_ready), 32'(!m_we && !m_full));
      if (imem_we === 1'b1) wr_log.push_back(imem_addr);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int sel, input int f_rs, input int f_rt, input int f_rd,
                       input int f_sa, input int f_imm, input int f_tgt);
    opsel = 5'(sel); rs = 5'(f_rs); rt = 5'(f_rt); rd = 5'(f_rd); sa = 5'(f_sa);
    imm = 16'(f_imm); target = 26'(f_tgt);
    req_valid = 1'b1;
  endtask

  // One request, then the write cycle checked against literal values
  task automatic send_expect(input string name, input int sel, input int f_rs, input int f_rt,
                             input int f_rd, input int f_sa, input int f_imm, input int f_tgt,
                             input logic [31:0] e_addr, input logic [31:0] e_data);
    drive(sel, f_rs, f_rt, f_rd, f_sa, f_imm, f_tgt);
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    chk({name, "_we"}, 32'(imem_we), 32'h1);
    chk({name, "_addr"}, imem_addr, e_addr);
    chk({name, "_data"}, imem_wdata, e_data);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the reference encoder against hand-derived words
    chk("ref_add", ref_enc(0, 1, 2, 3, 0, 0, 0), {1'b0, 32'h00221820});
    chk("ref_jr", ref_enc(8, 31, 9, 9, 9, 0, 0), {1'b0, 32'h03E00008});
    chk("ref_beq", ref_enc(15, 1, 2, 0, 0, 16'hFFFF, 0), {1'b0, 32'h1022FFFF});
    chk("ref_lui", ref_enc(17, 9, 5, 0, 0, 16'h1234, 0), {1'b0, 32'h3C051234});
    chk("ref_ill", 32'(ref_enc(25, 0, 0, 0, 0, 0, 0) >> 32), 32'h1);

    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_flags", {30'h0, full, err}, 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    tick();

    send_expect("add", 0, 1, 2, 3, 0, 0, 0, 32'h0, 32'h00221820);
    @(negedge clock);
    chk("add_count", 32'(count), 32'h1);
    tick();

    do_clear();
    send_expect("addi", 9, 0, 1, 0, 0, 5, 0, 32'h0, 32'h20010005);
    send_expect("lw", 13, 1, 2, 0, 0, 4, 0, 32'h4, 32'h8C220004);

    do_clear();
    send_expect("sll", 5, 7, 2, 4, 3, 0, 0, 32'h0, 32'h000220C0);
    send_expect("j", 18, 0, 0, 0, 0, 0, 32'h10, 32'h4, 32'h08000010);

    // Illegal opsel: sticky err, no write, address held
    drive(25, 1, 1, 1, 1, 1, 1);
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_we", 32'(imem_we), 32'h0);
    tick();
    send_expect("sub", 1, 6, 7, 5, 0, 0, 0, 32'h8, 32'h00C72822);
    send_expect("ori", 11, 3, 4, 0, 0, 16'hBEEF, 0, 32'hC, 32'h3464BEEF);
    @(negedge clock);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_ready", 32'(req_ready), 32'h0);
    chk("fill_err_sticky", 32'(err), 32'h1);
    tick();

    do_clear();
    @(negedge clock);
    chk("clr_addr", imem_addr, 32'h0);
    chk("clr_state", {count, full, err}, 32'h0);
    tick();

    // Valid held high until full: exactly four writes, then nothing
    wr_log.delete();
    drive(2, 1, 2, 3, 0, 0, 0);
    repeat (14) tick();
    req_valid = 1'b0;
    chk("hold_nwr", 32'(wr_log.size()), 32'h4);
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) chk("hold_addr", wr_log[i], 32'(4 * i));
    @(negedge clock);
    chk("hold_full", 32'(full), 32'h1);
    chk("hold_data", imem_wdata, 32'h00221824);
    tick();
    do_clear();

    // clear collides with a request
    drive(0, 1, 2, 3, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    chk("clrreq_we", 32'(imem_we), 32'h0);
    chk("clrreq_count", 32'(count), 32'h0);
    tick();

    // reset lands in the write cycle
    drive(17, 9, 5, 0, 0, 16'h1234, 0);
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rstwr_we", 32'(imem_we), 32'h0);
    chk("rstwr_count", 32'(count), 32'h0);
    tick();

    // Every legal and a few illegal opsels with random fields, model-checked
    for (int s = 0; s < 24; s++) begin
      do_clear();
      drive(s, int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(31)), int'($urandom_range(65535)), int'($urandom_range(32'h3FFFFFF)));
      tick();
      req_valid = 1'b0;
      tick(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_inst_enc.md
PIPE_INST_ENC -- requirements
Module: pipe_inst_enc

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0, byte address of first instruction word written.
REQ-002 Parameter DEPTH, default 64, number of instruction-memory words available (power of two, 2..1024).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 clear  in  1  synchronous restart: address back to BASE_ADDR, count/full/err cleared.
REQ-006 req_valid  in  1  instruction request present.
REQ-007 req_ready  out  1  encoder can accept request this cycle.
REQ-008 opsel  in  5  instruction select: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal; 20-31 illegal.
REQ-009 rs, rt, rd, sa  in  5 each  register/shift fields.
REQ-010 imm  in  16  immediate / branch offset; target  in  26  jump target.
REQ-011 imem_we  out  1  one-cycle instruction-memory write strobe.
REQ-012 imem_addr  out  32  byte address of write; imem_wdata  out  32  encoded word.
REQ-013 count  out  11  words written since reset/clear; full  out  1; err  out  1 (sticky illegal opsel).

Function
REQ-014 Handshake: request accepted in cycle N iff req_valid & req_ready; all request fields sampled in cycle N only.
REQ-015 FSM states IDLE, WRITE, FULL; IDLE->WRITE on legal accept; WRITE->IDLE after write unless last word written, then WRITE->FULL; FULL held until clear/reset.
REQ-016 req_ready = 1 only in IDLE with clear low; 0 in WRITE and FULL (max throughput one word per 2 cycles).
REQ-017 Legal accept in cycle N: imem_we=1 in cycle N+1 only, with registered imem_wdata and current imem_addr.
REQ-018 After each write imem_addr += 4 and count += 1; after DEPTH-th write full=1, no wrap-around.
REQ-019 R-type (opsel 0-8): op=000000; func add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
REQ-020 R-type fields: add..xor use rs,rt,rd, sa=0; shifts use rt,rd,sa, rs=0; jr uses rs, rt=rd=sa=0.
REQ-021 I-type op: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111; word = op,rs,rt,imm; lui forces rs=0.
REQ-022 J-type op: j 000010, jal 000011; word = op,target.
REQ-023 Illegal opsel accepted (ready high): err=1, no write, address/count unchanged, state stays IDLE.
REQ-024 clear has priority over a simultaneous handshake: request not accepted, in-flight write in WRITE suppressed.
REQ-025 Outputs change only on clock edges (all registered).

Reset
REQ-026 reset (and clear) next edge: state IDLE, imem_addr=BASE_ADDR, imem_we=0, imem_wdata=0, count=0, full=0, err=0; req_ready=1 cycle after reset deasserts.
REQ-027 reset asserted during WRITE: imem_we low from next cycle, pending word discarded.

Structure
REQ-028 Shared package holds opsel enumeration, 6-bit op/func constants, state encoding.
REQ-029 Combinational encoder split into sub-module pipe_inst_fmt (opsel+fields -> 32-bit word, illegal flag); FSM, counters in top.

Verification
REQ-030 add rd=3 rs=1 rt=2 -> imem_we one cycle later, addr 0x0, wdata 0x00221820, count=1.
REQ-031 addi rt=1 rs=0 imm=0x0005 then lw rt=2 rs=1 imm=4 -> 0x20010005 @0x0, 0x8C220004 @0x4.
REQ-032 sll rd=4 rt=2 sa=3 rs=7 -> 0x000220C0 (rs ignored); j target=0x0000010 -> 0x08000010.
REQ-033 DEPTH=4, valid held high -> writes at 0x0,0x4,0x8,0xC, full=1, req_ready=0, fifth request never accepted; clear -> addr 0x0, full=0, count=0.
REQ-034 opsel=25 -> err=1, no imem_we, next legal request written at unchanged address.
REQ-035 clear and req_valid high same cycle -> no accept, no write; reset during WRITE -> no imem_we.
